fpga_rst_seq: RTL and testbench
===============================

Name: fpga_rst_seq

Overview:
- Parametrised reset sequencer for the FPGA clock/reset path. It runs on the PLL output clock.
- It combines three reset sources: the board reset, the PLL lock status and a software reset request.
- Reset assertion is immediate and applies to every output at once. Release is staged: after lock filtering and a stretch period, NUM_RST domain resets deassert one at a time, in a fixed order and a fixed number of cycles apart.
- It also reports the cause of the last reset and counts lock-loss events.

Parameters:
- SYNC_STAGES, 3: flop depth of the reset-release and lock synchronisers; minimum 2.
- NUM_RST, 4: number of staged active-low reset outputs; 1..16.
- LOCK_FILT, 8: consecutive synchronised lock-high cycles required before lock is accepted; at least 1.
- STRETCH_CYC, 100: cycles all outputs are held low after lock is accepted; at least 1.
- STAGE_GAP, 16: cycles between successive output releases; at least 1.
- CNT_W, 8: width of the lock-loss counter.

Ports:
- fpga_clk_in, in, 1: system clock (PLL output, buffered).
- fpga_rst_in, in, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised internally.
- pll_locked_in, in, 1: PLL LOCKED. Asynchronous to fpga_clk_in; synchronised internally.
- sw_rst_req, in, 1: single-cycle software reset request, synchronous to fpga_clk_in.
- rst_out_n, out, NUM_RST: staged active-low resets. Bit 0 releases first.
- sys_ready, out, 1: high only when every rst_out_n bit is high and the FSM is in RUN.
- rst_cause, out, 2: cause of the last reset. 00 = power-on/board, 01 = lock loss, 10 = software.
- lock_loss_cnt, out, CNT_W: saturating count of lock-loss events.

Behaviour:
- Reset values, while fpga_rst_in is low (all outputs clear asynchronously):
  - rst_out_n = 0, sys_ready = 0, rst_cause = 00, lock_loss_cnt = 0.
  - FSM is in WAIT_LOCK; all counters are 0.
- Synchronisers:
  - rst_sync: SYNC_STAGES flops with D tied to 1, async-cleared by fpga_rst_in.
  - lock_s: SYNC_STAGES flops on pll_locked_in, async-cleared by fpga_rst_in.
  - The FSM advances only while rst_sync = 1.
- FSM state WAIT_LOCK:
  - filt_cnt increments while lock_s = 1 and clears to 0 when lock_s = 0.
  - When filt_cnt reaches LOCK_FILT, go to STRETCH with stretch_cnt = 0.
  - sw_rst_req is ignored in this state.
- FSM state STRETCH:
  - stretch_cnt increments each cycle; at STRETCH_CYC, go to RELEASE with idx = 0 and gap_cnt = 0.
  - sw_rst_req restarts stretch_cnt at 0 and sets rst_cause = 10.
- FSM state RELEASE:
  - On entry, rst_out_n[0] is set high.
  - Every STAGE_GAP cycles, idx increments and rst_out_n[idx] is set high.
  - After rst_out_n[NUM_RST-1] is set, go to RUN on the next cycle. sys_ready rises on entry to RUN.
- FSM state RUN: hold all outputs high.
- Lock loss (lock_s = 0 in STRETCH, RELEASE or RUN):
  - Registered next edge: rst_out_n = 0, sys_ready = 0, rst_cause = 01, lock_loss_cnt increments (saturating at all-ones).
  - Go to WAIT_LOCK with filt_cnt = 0.
- Software reset (sw_rst_req = 1 in RELEASE or RUN):
  - Next edge: rst_out_n = 0, sys_ready = 0, rst_cause = 10.
  - Go to STRETCH with stretch_cnt = 0.
- Simultaneous events: lock loss and sw_rst_req in the same cycle resolve as lock loss; rst_cause = 01.
- rst_cause holds its value until the next event. Board reset clears it to 00.
- Release timing: let cycle 0 be the first fpga_clk_in edge with fpga_rst_in high, with pll_locked_in already high.
  - rst_out_n[k] rises at edge T0 + k*STAGE_GAP, where T0 = SYNC_STAGES + LOCK_FILT + STRETCH_CYC.
  - sys_ready rises at T0 + (NUM_RST-1)*STAGE_GAP + 1.
- rst_out_n bits are driven directly from flops (no combinational output path).
- Once released, a bit never glitches low except on a reset event. Once asserted by an event, all bits stay low until re-release.
- Mid-operation board reset: all outputs clear immediately (asynchronously) and the full sequence restarts from cycle 0.

Decomposition:
- Package fpga_rst_pkg:
  - FSM state encoding: WAIT_LOCK, STRETCH, RELEASE, RUN.
  - Cause constants: CAUSE_POR = 2'b00, CAUSE_LOCK = 2'b01, CAUSE_SW = 2'b10.
  - Counter width helper (clog2).
- Sub-module fpga_sync_bit: parametrised SYNC_STAGES synchroniser with async active-low clear. It is instantiated twice, for rst_sync and lock_s.

Test Plan:
- Power-up, default parameters, lock high throughout, release fpga_rst_in → rst_out_n[0..3] rise at edges 111, 127, 143, 159; sys_ready rises at 160; rst_cause = 00.
- Lock bounce: lock toggles low for 1 cycle every 5 cycles for 50 cycles, then stays high → no release until 8 consecutive synchronised-high cycles; then the standard spacing applies.
- Lock loss in RUN: drop pll_locked_in → rst_out_n = 0 exactly SYNC_STAGES+1 edges later; rst_cause = 01; lock_loss_cnt = 1. Restore lock → full re-sequence.
- sw_rst_req pulse in RUN → next edge rst_out_n = 0 and rst_cause = 10; release 100 cycles later with no lock filter. A second pulse during STRETCH restarts the 100-cycle count.
- Simultaneous lock drop and sw_rst_req in RELEASE → rst_cause = 01 and FSM in WAIT_LOCK. Separately, drive 260 lock losses with CNT_W = 8 → lock_loss_cnt saturates at 255.
- fpga_rst_in asserted mid-RELEASE (idx = 2), asynchronously between clock edges → all outputs 0 immediately, before the next edge; rst_cause = 00; lock_loss_cnt = 0.

Source files
------------

// File: rtl/fpga_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpga_rst_pkg                                                               |
// | Shared encodings and width helper for the FPGA reset sequencer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fpga_rst_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [STATE_W-1:0] ST_STRETCH   = 2'd1;
  localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_sync_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpga_sync_bit                                                              |
// | Multi-flop single-bit synchroniser with asynchronous active-low clear.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpga_sync_bit
  import fpga_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic fpga_clk_in,
  input  logic fpga_rst_in,
  input  logic async_d,
  output logic sync_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
    if (!fpga_rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_d};
    end
  end

  assign sync_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fpga_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpga_rst_seq                                                               |
// | Lock-filtered, stretched and staged reset release with cause reporting.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int NUM_RST     = 4,
  parameter int LOCK_FILT   = 8,
  parameter int STRETCH_CYC = 100,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 8
) (
  input  logic               fpga_clk_in,
  input  logic               fpga_rst_in,
  input  logic               pll_locked_in,
  input  logic               sw_rst_req,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               sys_ready,
  output logic [1:0]         rst_cause,
  output logic [CNT_W-1:0]   lock_loss_cnt
);

  localparam int FILT_W = cnt_width(LOCK_FILT);
  localparam int STR_W  = cnt_width(STRETCH_CYC - 1);
  localparam int GAP_W  = cnt_width(STAGE_GAP - 1);
  localparam int IDX_W  = cnt_width(NUM_RST - 1);

  localparam logic [FILT_W-1:0] C_FILT_MAX = FILT_W'(LOCK_FILT);
  localparam logic [STR_W-1:0]  C_STR_LAST = STR_W'(STRETCH_CYC - 1);
  localparam logic [GAP_W-1:0]  C_GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(NUM_RST - 1);

  logic w_rst_sync;
  logic w_lock_s;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;

  logic [FILT_W-1:0]  r_filt_cnt,    w_filt_nxt;
  logic [STR_W-1:0]   r_stretch_cnt, w_stretch_nxt;
  logic [GAP_W-1:0]   r_gap_cnt,     w_gap_nxt;
  logic [IDX_W-1:0]   r_idx,         w_idx_nxt;
  logic [NUM_RST-1:0] r_rst_out_n,   w_rst_out_n_nxt;
  logic               r_sys_ready,   w_sys_ready_nxt;
  logic [1:0]         r_rst_cause,   w_rst_cause_nxt;
  logic [CNT_W-1:0]   r_loss_cnt,    w_loss_cnt_nxt;

  logic w_lock_loss;
  logic w_sw_evt;

  fpga_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .fpga_clk_in (fpga_clk_in),
    .fpga_rst_in (fpga_rst_in),
    .async_d     (1'b1),
    .sync_q      (w_rst_sync)
  );

  fpga_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .fpga_clk_in (fpga_clk_in),
    .fpga_rst_in (fpga_rst_in),
    .async_d     (pll_locked_in),
    .sync_q      (w_lock_s)
  );

  // Lock loss outranks a coincident software request.
  assign w_lock_loss = w_rst_sync && !w_lock_s && (r_state != ST_WAIT_LOCK);
  assign w_sw_evt    = w_rst_sync && sw_rst_req && !w_lock_loss && (r_state != ST_WAIT_LOCK);

  always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
    if (!fpga_rst_in) begin
      r_state <= ST_WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rst_sync) begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (w_lock_s && (r_filt_cnt == C_FILT_MAX)) w_state_nxt = ST_STRETCH;
        end
        ST_STRETCH: begin
          if (!w_lock_s)                                      w_state_nxt = ST_WAIT_LOCK;
          else if (!sw_rst_req && (r_stretch_cnt == C_STR_LAST)) w_state_nxt = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_lock_s)                 w_state_nxt = ST_WAIT_LOCK;
          else if (sw_rst_req)           w_state_nxt = ST_STRETCH;
          else if (r_idx == C_IDX_LAST)  w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lock_s)       w_state_nxt = ST_WAIT_LOCK;
          else if (sw_rst_req) w_state_nxt = ST_STRETCH;
        end
        default: w_state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  always_comb begin
    w_filt_nxt      = r_filt_cnt;
    w_stretch_nxt   = r_stretch_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_idx_nxt       = r_idx;
    w_rst_out_n_nxt = r_rst_out_n;
    w_sys_ready_nxt = r_sys_ready;
    w_rst_cause_nxt = r_rst_cause;
    w_loss_cnt_nxt  = r_loss_cnt;
    if (w_lock_loss) begin
      w_rst_out_n_nxt = '0;
      w_sys_ready_nxt = 1'b0;
      w_rst_cause_nxt = CAUSE_LOCK;
      w_filt_nxt      = '0;
      if (r_loss_cnt != {CNT_W{1'b1}}) w_loss_cnt_nxt = r_loss_cnt + CNT_W'(1);
    end else if (w_sw_evt) begin
      w_rst_out_n_nxt = '0;
      w_sys_ready_nxt = 1'b0;
      w_rst_cause_nxt = CAUSE_SW;
      w_stretch_nxt   = '0;
    end else if (w_rst_sync) begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (!w_lock_s) begin
            w_filt_nxt = '0;
          end else if (r_filt_cnt == C_FILT_MAX) begin
            w_filt_nxt    = '0;
            w_stretch_nxt = '0;
          end else begin
            w_filt_nxt = r_filt_cnt + FILT_W'(1);
          end
        end
        ST_STRETCH: begin
          if (r_stretch_cnt == C_STR_LAST) begin
            w_idx_nxt       = '0;
            w_gap_nxt       = '0;
            w_rst_out_n_nxt = NUM_RST'(1);
          end else begin
            w_stretch_nxt = r_stretch_cnt + STR_W'(1);
          end
        end
        ST_RELEASE: begin
          // Outputs fill as a thermometer: shifting in a 1 releases the next bit.
          if (r_idx == C_IDX_LAST) begin
            w_sys_ready_nxt = 1'b1;
          end else if (r_gap_cnt == C_GAP_LAST) begin
            w_gap_nxt       = '0;
            w_idx_nxt       = r_idx + IDX_W'(1);
            w_rst_out_n_nxt = (r_rst_out_n << 1) | NUM_RST'(1);
          end else begin
            w_gap_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
    if (!fpga_rst_in) begin
      r_filt_cnt    <= '0;
      r_stretch_cnt <= '0;
      r_gap_cnt     <= '0;
      r_idx         <= '0;
      r_rst_out_n   <= '0;
      r_sys_ready   <= 1'b0;
      r_rst_cause   <= CAUSE_POR;
      r_loss_cnt    <= '0;
    end else begin
      r_filt_cnt    <= w_filt_nxt;
      r_stretch_cnt <= w_stretch_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_idx         <= w_idx_nxt;
      r_rst_out_n   <= w_rst_out_n_nxt;
      r_sys_ready   <= w_sys_ready_nxt;
      r_rst_cause   <= w_rst_cause_nxt;
      r_loss_cnt    <= w_loss_cnt_nxt;
    end
  end

  assign rst_out_n     = r_rst_out_n;
  assign sys_ready     = r_sys_ready;
  assign rst_cause     = r_rst_cause;
  assign lock_loss_cnt = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpga_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpga_rst_seq                                                            |
// | Scoreboard bench: timestamp-based reference model versus the sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fpga_rst_seq;

  localparam int SYNC_STAGES = 3;
  localparam int NUM_RST     = 4;
  localparam int LOCK_FILT   = 8;
  localparam int STRETCH_CYC = 100;
  localparam int STAGE_GAP   = 16;
  localparam int CNT_W       = 8;

  logic               fpga_clk_in = 1'b0;
  logic               fpga_rst_in = 1'b1;
  logic               pll_locked_in = 1'b0;
  logic               sw_rst_req = 1'b0;
  logic [NUM_RST-1:0] rst_out_n;
  logic               sys_ready;
  logic [1:0]         rst_cause;
  logic [CNT_W-1:0]   lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  fpga_rst_seq #(
    .SYNC_STAGES(SYNC_STAGES), .NUM_RST(NUM_RST), .LOCK_FILT(LOCK_FILT),
    .STRETCH_CYC(STRETCH_CYC), .STAGE_GAP(STAGE_GAP), .CNT_W(CNT_W)
  ) dut (
    .fpga_clk_in   (fpga_clk_in),
    .fpga_rst_in   (fpga_rst_in),
    .pll_locked_in (pll_locked_in),
    .sw_rst_req    (sw_rst_req),
    .rst_out_n     (rst_out_n),
    .sys_ready     (sys_ready),
    .rst_cause     (rst_cause),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 fpga_clk_in = ~fpga_clk_in;

  localparam int VAL_W = NUM_RST + 1 + 2 + CNT_W;

  typedef struct packed {
    int                 cyc;
    logic [NUM_RST-1:0] rn;
    logic               rdy;
    logic [1:0]         cause;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  exp_t q_exp[$];

  // Reference model: event timestamps instead of counters.
  int         cyc = -1;
  int         n_edge;
  int         good_run;
  int         st_time;
  int         rel_time;
  int         m_cnt;
  logic [1:0] m_cause;
  bit         m_ls;
  bit         lq[$];
  logic [VAL_W-1:0] last_val = '1;

  task automatic model_push();
    exp_t e;
    int   el;
    e.cyc = cyc;
    e.rn  = '0;
    e.rdy = 1'b0;
    if (rel_time >= 0) begin
      el = cyc - rel_time;
      for (int k = 0; k < NUM_RST; k++) if (el >= k * STAGE_GAP) e.rn[k] = 1'b1;
      e.rdy = (el >= (NUM_RST - 1) * STAGE_GAP + 1);
    end
    e.cause = m_cause;
    e.cnt   = CNT_W'(m_cnt);
    if ({e.rn, e.rdy, e.cause, e.cnt} !== last_val) begin
      q_exp.push_back(e);
      last_val = {e.rn, e.rdy, e.cause, e.cnt};
    end
  endtask

  task automatic model_step();
    bit active;
    active = (st_time >= 0) || (rel_time >= 0);
    if (active && !m_ls) begin
      m_cause = 2'b01;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      st_time  = -1;
      rel_time = -1;
      good_run = 0;
    end else if (active) begin
      if (sw_rst_req) begin
        m_cause  = 2'b10;
        st_time  = cyc;
        rel_time = -1;
      end else if (rel_time < 0 && cyc == st_time + STRETCH_CYC) begin
        rel_time = cyc;
      end
    end else begin
      if (!m_ls) good_run = 0;
      else if (good_run == LOCK_FILT) st_time = cyc;
      else good_run++;
    end
  endtask

  always @(posedge fpga_clk_in or negedge fpga_rst_in) begin
    if (!fpga_rst_in) begin
      lq = {};
      for (int i = 0; i < SYNC_STAGES; i++) lq.push_back(1'b0);
      cyc = -1; n_edge = 0; good_run = 0; st_time = -1; rel_time = -1;
      m_cnt = 0; m_cause = 2'b00;
    end else begin
      cyc++;
      m_ls = lq.pop_front();
      lq.push_back(pll_locked_in);
      if (n_edge >= SYNC_STAGES) model_step();
      n_edge++;
    end
    model_push();
  end

  // Monitor: every visible output change consumes one expected event.
  task automatic check_pop();
    exp_t e;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $display("FAIL unexpected_change cyc=%0d rst_out_n=%b sys_ready=%0b rst_cause=%b lock_loss_cnt=%0d, none required",
               cyc, rst_out_n, sys_ready, rst_cause, lock_loss_cnt);
      return;
    end
    e = q_exp.pop_front();
    if (e.cyc != cyc || e.rn !== rst_out_n || e.rdy !== sys_ready ||
        e.cause !== rst_cause || e.cnt !== lock_loss_cnt) begin
      errors++;
      $display("FAIL output_event got cyc=%0d rst_out_n=%b sys_ready=%0b rst_cause=%b cnt=%0d want cyc=%0d rst_out_n=%b sys_ready=%0b rst_cause=%b cnt=%0d",
               cyc, rst_out_n, sys_ready, rst_cause, lock_loss_cnt,
               e.cyc, e.rn, e.rdy, e.cause, e.cnt);
    end
  endtask

  initial begin
    logic [VAL_W-1:0] prev, now;
    @(negedge fpga_rst_in);
    #1;
    check_pop();
    prev = {rst_out_n, sys_ready, rst_cause, lock_loss_cnt};
    forever begin
      @(negedge fpga_clk_in or negedge fpga_rst_in);
      #1;
      now = {rst_out_n, sys_ready, rst_cause, lock_loss_cnt};
      if (now !== prev) begin
        check_pop();
        prev = now;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge fpga_clk_in);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int i = 0;
    while (sys_ready !== 1'b1 && i < budget) begin
      @(negedge fpga_clk_in);
      i++;
    end
    checks++;
    if (sys_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout sys_ready=%0b want 1 within %0d cycles", tag, sys_ready, budget);
    end
  endtask

  task automatic wait_bit(input int k, input int budget, input string tag);
    int i = 0;
    while (rst_out_n[k] !== 1'b1 && i < budget) begin
      @(negedge fpga_clk_in);
      i++;
    end
    checks++;
    if (rst_out_n[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout rst_out_n[%0d]=%0b want 1 within %0d cycles", tag, k, rst_out_n[k], budget);
    end
  endtask

  task automatic board_reset_async();
    @(posedge fpga_clk_in);
    #2 fpga_rst_in = 1'b0;
    cycles(3);
  endtask

  initial begin
    #1 fpga_rst_in = 1'b0;
    pll_locked_in = 1'b1;
    cycles(3);
    fpga_rst_in = 1'b1;
    wait_ready(400, "powerup");

    // Lock bounce straight out of a board reset.
    board_reset_async();
    fpga_rst_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      pll_locked_in = (i % 5 != 4);
      cycles(1);
    end
    pll_locked_in = 1'b1;
    wait_ready(400, "lock_bounce");

    // Lock loss while running.
    pll_locked_in = 1'b0;
    cycles($urandom_range(1, 10));
    pll_locked_in = 1'b1;
    wait_ready(400, "lock_loss_run");

    // Software reset in RUN, then a second request during the stretch.
    sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0;
    cycles($urandom_range(20, 80));
    sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0;
    wait_ready(300, "sw_restretch");

    // Lock drop and software request land on the same sequencer edge during release.
    sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0;
    wait_bit(1, 200, "reach_release");
    pll_locked_in = 1'b0;
    cycles(SYNC_STAGES);
    sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0;
    cycles(2);
    pll_locked_in = 1'b1;
    wait_ready(400, "simultaneous");

    // Repeated lock losses past counter saturation.
    for (int i = 0; i < 260; i++) begin
      pll_locked_in = 1'b1;
      cycles($urandom_range(14, 20));
      pll_locked_in = 1'b0;
      cycles($urandom_range(1, 4));
    end
    pll_locked_in = 1'b1;
    wait_ready(400, "after_saturation");

    // Random lock glitches and software requests.
    for (int i = 0; i < 1500; i++) begin
      pll_locked_in = ($urandom_range(0, 99) < 97);
      sw_rst_req    = ($urandom_range(0, 99) < 2);
      cycles(1);
    end
    pll_locked_in = 1'b1;
    sw_rst_req    = 1'b0;
    wait_ready(400, "random");

    // Board reset asserted between edges while idx = 2.
    sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0;
    wait_bit(2, 200, "reach_idx2");
    board_reset_async();
    fpga_rst_in = 1'b1;
    wait_ready(400, "after_board_reset");

    cycles(5);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding want 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
